// File: rtl/b2_rr_sel_3_pkg.sv
// Shared definitions for the 3-source round-robin sequencer:
// select codes, handshake state encoding and pointer rotation.
package b2_rr_pkg;

   localparam logic [1:0] SEL_D0 = 2'b00;
   localparam logic [1:0] SEL_D1 = 2'b01;
   localparam logic [1:0] SEL_D2 = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   // Rotation wraps 2 -> 0 explicitly; the unreachable code 3 also maps to 0.
   function automatic logic [1:0] next_idx(input logic [1:0] last);
      logic [1:0] nxt;
      case (last)
         SEL_D0:  nxt = SEL_D1;
         SEL_D1:  nxt = SEL_D2;
         default: nxt = SEL_D0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/b2_rr_sel_3_if.sv
// Source/consumer bundle of the round-robin sequencer. The master side drives
// requests, data and out_ready; the slave side (the sequencer) answers.
interface b2_rr_sel_3_if #(
   parameter int W     = 2,
   parameter int CNT_W = 8
);
   logic [2:0]       req;
   logic [W-1:0]     d0;
   logic [W-1:0]     d1;
   logic [W-1:0]     d2;
   logic [2:0]       ack;
   logic             out_ready;
   logic             out_valid;
   logic [1:0]       sel;
   logic [W-1:0]     y;
   logic [CNT_W-1:0] xfer_cnt;

   modport master (
      output req, d0, d1, d2, out_ready,
      input  ack, out_valid, sel, y, xfer_cnt
   );

   modport slave (
      input  req, d0, d1, d2, out_ready,
      output ack, out_valid, sel, y, xfer_cnt
   );
endinterface

// File: rtl/b2_rr_sel_3_pick.sv
// Combinational round-robin picker: first requester after 'last' in the
// rotating order last+1, last+2, last+3 (mod 3).
module b2_rr_pick_3
   import b2_rr_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] grant,
   output logic       any_req
);

   logic [1:0] c0_s;
   logic [1:0] c1_s;
   logic [1:0] c2_s;
   logic [3:0] req_ext_s;

   // Candidates always stay in 0..2, so the padded bit is never selected.
   assign c0_s      = next_idx(last);
   assign c1_s      = next_idx(c0_s);
   assign c2_s      = next_idx(c1_s);
   assign req_ext_s = {1'b0, req};
   assign any_req   = |req;

   // Priority search over the three rotated candidates.
   always_comb begin
      grant = c0_s;
      if (req_ext_s[c0_s]) begin
         grant = c0_s;
      end else if (req_ext_s[c1_s]) begin
         grant = c1_s;
      end else if (req_ext_s[c2_s]) begin
         grant = c2_s;
      end else begin
         grant = c0_s;
      end
   end

endmodule

// File: rtl/b2_rr_sel_3.sv
// Round-robin sequencer for the 3:1 mux stage: arbitrates three sources,
// registers the winner's data behind a valid/ready slot and counts transfers.
module b2_rr_sel_3
   import b2_rr_pkg::*;
#(
   parameter int W     = 2,
   parameter int CNT_W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   b2_rr_sel_3_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r,  state_nxt;
   logic [1:0]       sel_r,    sel_nxt;
   logic [1:0]       last_r,   last_nxt;
   logic [W-1:0]     y_r,      y_nxt;
   logic [2:0]       ack_r,    ack_nxt;
   logic [CNT_W-1:0] cnt_r,    cnt_nxt;

   logic [1:0]       grant_s;
   logic             any_req_s;
   logic             load_s;
   logic [W-1:0]     data_s;
   logic [2:0]       grant_oh_s;

   b2_rr_pick_3 u_pick (
      .req     (bus.req),
      .last    (last_r),
      .grant   (grant_s),
      .any_req (any_req_s)
   );

   // Data and one-hot acknowledge of the candidate winner.
   always_comb begin
      data_s     = {W{1'b0}};
      grant_oh_s = 3'b000;
      case (grant_s)
         SEL_D0: begin
            data_s     = bus.d0;
            grant_oh_s = 3'b001;
         end
         SEL_D1: begin
            data_s     = bus.d1;
            grant_oh_s = 3'b010;
         end
         SEL_D2: begin
            data_s     = bus.d2;
            grant_oh_s = 3'b100;
         end
         default: begin
            data_s     = {W{1'b0}};
            grant_oh_s = 3'b000;
         end
      endcase
   end

   // Slot handshake: a new grant loads only when the slot is empty or draining.
   always_comb begin
      state_nxt = state_r;
      sel_nxt   = sel_r;
      last_nxt  = last_r;
      y_nxt     = y_r;
      ack_nxt   = 3'b000;
      cnt_nxt   = cnt_r;
      load_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               load_s    = 1'b1;
               state_nxt = ST_FULL;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_FULL: begin
            if (bus.out_ready) begin
               cnt_nxt = cnt_r + CNT_ONE;
               if (any_req_s) begin
                  load_s    = 1'b1;
                  state_nxt = ST_FULL;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               state_nxt = ST_FULL;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (load_s) begin
         sel_nxt  = grant_s;
         last_nxt = grant_s;
         y_nxt    = data_s;
         ack_nxt  = grant_oh_s;
      end else begin
         ack_nxt  = 3'b000;
      end
   end

   // State and output registers; reset restarts arbitration at source 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         sel_r   <= SEL_D0;
         last_r  <= SEL_D2;
         y_r     <= {W{1'b0}};
         ack_r   <= 3'b000;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt;
         sel_r   <= sel_nxt;
         last_r  <= last_nxt;
         y_r     <= y_nxt;
         ack_r   <= ack_nxt;
         cnt_r   <= cnt_nxt;
      end
   end

   assign bus.out_valid = (state_r == ST_FULL);
   assign bus.sel       = sel_r;
   assign bus.y         = y_r;
   assign bus.ack       = ack_r;
   assign bus.xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_b2_rr_sel_3.sv
// Directed bench for b2_rr_sel_3: stimulus pushes expected grants into a
// queue; a negedge monitor pops and checks them on every ack pulse.
module tb_b2_rr_sel_3;

   typedef struct {
      logic [1:0] sel;
      logic [1:0] y;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   exp_t exp_q[$];

   b2_rr_sel_3_if #(.W(2), .CNT_W(2)) bus ();

   b2_rr_sel_3 #(.W(2), .CNT_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] s, input logic [1:0] yv);
      exp_t e;
      e.sel = s;
      e.y   = yv;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [2:0] r, input logic rdy);
      bus.req       = r;
      bus.out_ready = rdy;
      @(negedge clk);
   endtask

   // Monitor: every ack pulse must match the oldest outstanding expected grant.
   always @(negedge clk) begin
      exp_t       e;
      logic [2:0] ack_exp;
      if (rst_n && bus.ack != 3'b000) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got ack=%b sel=%b with no grant expected", bus.ack, bus.sel);
         end else begin
            e       = exp_q.pop_front();
            ack_exp = 3'b001 << e.sel;
            chk("grant_sel", {6'd0, bus.sel}, {6'd0, e.sel});
            chk("grant_y",   {6'd0, bus.y},   {6'd0, e.y});
            chk("grant_ack", {5'd0, bus.ack}, {5'd0, ack_exp});
            chk("grant_valid", {7'd0, bus.out_valid}, 8'd1);
         end
      end
   end

   logic [1:0] rr_sel [6] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
   logic [1:0] rr_cnt [6] = '{2'd1,  2'd2,  2'd3,  2'd0,  2'd1,  2'd2};
   logic [1:0] rs_sel [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
   logic [1:0] rs_y   [4] = '{2'b11, 2'b01, 2'b10, 2'b11};

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.req       = 3'b000;
      bus.out_ready = 1'b0;
      bus.d0        = 2'b00;
      bus.d1        = 2'b01;
      bus.d2        = 2'b10;
      repeat (2) @(negedge clk);
      chk("rst_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("rst_sel",   {6'd0, bus.sel},       8'd0);
      chk("rst_y",     {6'd0, bus.y},         8'd0);
      chk("rst_ack",   {5'd0, bus.ack},       8'd0);
      chk("rst_cnt",   {6'd0, bus.xfer_cnt},  8'd0);

      rst_n = 1'b1;
      step(3'b000, 1'b1);
      step(3'b000, 1'b1);
      chk("idle_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("idle_sel",   {6'd0, bus.sel},       8'd0);
      chk("idle_cnt",   {6'd0, bus.xfer_cnt},  8'd0);

      // Single request from source 1, then drop it.
      push(2'b01, 2'b01);
      step(3'b010, 1'b1);
      chk("single_valid", {7'd0, bus.out_valid}, 8'd1);
      step(3'b000, 1'b1);
      chk("single_drain_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("single_drain_cnt",   {6'd0, bus.xfer_cnt},  8'd1);
      chk("single_drain_sel",   {6'd0, bus.sel},       8'd1);
      chk("single_drain_ack",   {5'd0, bus.ack},       8'd0);

      // Round robin with all sources requesting; last grant was source 1.
      for (int k = 0; k < 6; k++) begin
         push(rr_sel[k], rr_sel[k]);
         step(3'b111, 1'b1);
         chk("rr_cnt", {6'd0, bus.xfer_cnt}, {6'd0, rr_cnt[k]});
      end

      // Backpressure holds the slot stable.
      for (int k = 0; k < 4; k++) begin
         step(3'b111, 1'b0);
         chk("bp_sel",   {6'd0, bus.sel},       8'd1);
         chk("bp_y",     {6'd0, bus.y},         8'd1);
         chk("bp_ack",   {5'd0, bus.ack},       8'd0);
         chk("bp_valid", {7'd0, bus.out_valid}, 8'd1);
         chk("bp_cnt",   {6'd0, bus.xfer_cnt},  8'd2);
      end
      push(2'b10, 2'b10);
      step(3'b111, 1'b1);
      chk("bp_release_cnt", {6'd0, bus.xfer_cnt}, 8'd3);
      step(3'b000, 1'b1);
      chk("cnt_wrap_a", {6'd0, bus.xfer_cnt},  8'd0);
      chk("bp_idle",    {7'd0, bus.out_valid}, 8'd0);

      // Skip/wrap: last=2 and only source 2 requests, then sources 0 and 1.
      bus.d0 = 2'b11;
      push(2'b10, 2'b10);
      step(3'b100, 1'b1);
      push(2'b00, 2'b11);
      step(3'b011, 1'b1);
      push(2'b01, 2'b01);
      step(3'b011, 1'b1);
      chk("skip_cnt", {6'd0, bus.xfer_cnt}, 8'd2);
      step(3'b000, 1'b1);
      chk("skip_drain_cnt",   {6'd0, bus.xfer_cnt},  8'd3);
      chk("skip_drain_valid", {7'd0, bus.out_valid}, 8'd0);

      // Asynchronous reset while the slot is full.
      push(2'b10, 2'b10);
      step(3'b111, 1'b1);
      chk("pre_rst_valid", {7'd0, bus.out_valid}, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("arst_cnt",   {6'd0, bus.xfer_cnt},  8'd0);
      chk("arst_sel",   {6'd0, bus.sel},       8'd0);
      chk("arst_y",     {6'd0, bus.y},         8'd0);
      @(negedge clk);
      chk("arst_hold_ack",   {5'd0, bus.ack},       8'd0);
      chk("arst_hold_valid", {7'd0, bus.out_valid}, 8'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push(rs_sel[k], rs_y[k]);
         step(3'b111, 1'b1);
         chk("restart_cnt", {6'd0, bus.xfer_cnt}, k[7:0]);
      end
      step(3'b000, 1'b1);
      chk("cnt_wrap_b", {6'd0, bus.xfer_cnt},  8'd0);
      chk("end_valid",  {7'd0, bus.out_valid}, 8'd0);

      @(negedge clk);
      chk("pending_grants", exp_q.size() > 255 ? 8'hff : 8'(exp_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
